// File: rtl/tlk2711_wr_arb.sv
// Round-robin arbiter that shares the single tlk2711_dma write path among NUM_CH receive channels.
// One grant per DMA write command, held until wr_finish or until the transfer timer aborts it.
module tlk2711_wr_arb #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 48,
    parameter int DLEN_WIDTH     = 16,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int CMD_W         = DLEN_WIDTH + ADDR_WIDTH,
    localparam int KEEP_W        = DATA_WIDTH / 8,
    localparam int OWNER_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_soft_rst,
    input  logic [NUM_CH-1:0]            i_ch_cmd_req,
    input  logic [NUM_CH*CMD_W-1:0]      i_ch_cmd_data,
    output logic [NUM_CH-1:0]            o_ch_cmd_ack,
    output logic [NUM_CH-1:0]            o_ch_wr_finish,
    input  logic [NUM_CH-1:0]            i_ch_wr_valid,
    input  logic [NUM_CH*KEEP_W-1:0]     i_ch_wr_keep,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_ch_wr_data,
    output logic [NUM_CH-1:0]            o_ch_wr_ready,
    output logic                         o_wr_cmd_req,
    output logic [CMD_W-1:0]             o_wr_cmd_data,
    input  logic                         i_wr_cmd_ack,
    output logic                         o_dma_wr_valid,
    output logic [KEEP_W-1:0]            o_dma_wr_keep,
    output logic [DATA_WIDTH-1:0]        o_dma_wr_data,
    input  logic                         i_dma_wr_ready,
    input  logic                         i_wr_finish,
    output logic [OWNER_W-1:0]           o_owner,
    output logic                         o_busy,
    output logic                         o_timeout
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMR_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_LAST_I[TMR_W-1:0];
    localparam logic TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [OWNER_W-1:0] LAST_CH = OWNER_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [OWNER_W-1:0]  owner;
    logic [OWNER_W-1:0]  pick;
    logic [OWNER_W-1:0]  cand;
    logic                found;
    logic                any_req;
    logic [CMD_W-1:0]    pick_cmd;
    logic [NUM_CH-1:0]   owner_oh;
    logic [TMR_W-1:0]    timer;
    logic                tmo_hit;

    assign any_req = |i_ch_cmd_req;
    assign tmo_hit = TMO_EN && (timer == TMR_LAST);
    assign o_owner = owner;

    // Scan upward from the channel after the last owner so the one just served ranks lowest.
    always_comb begin
        pick  = owner;
        found = 1'b0;
        cand  = owner;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == LAST_CH) ? '0 : cand + OWNER_W'(1);
            if (!found && i_ch_cmd_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_cmd = '0;
        owner_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick == OWNER_W'(k))
                pick_cmd = i_ch_cmd_data[k*CMD_W +: CMD_W];
            owner_oh[k] = (owner == OWNER_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_soft_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = REQ;
            REQ:     if (i_wr_cmd_ack) state_nxt = XFER;
            XFER:    if (i_wr_finish || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner, latched command, timer and the one-cycle notification pulses.
    always_ff @(posedge clk) begin
        if (rst || i_soft_rst) begin
            owner          <= LAST_CH;
            o_wr_cmd_data  <= '0;
            o_ch_cmd_ack   <= '0;
            o_ch_wr_finish <= '0;
            o_timeout      <= 1'b0;
            timer          <= '0;
        end else begin
            o_ch_cmd_ack   <= '0;
            o_ch_wr_finish <= '0;
            o_timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner         <= pick;
                        o_wr_cmd_data <= pick_cmd;
                    end
                end
                REQ: begin
                    if (i_wr_cmd_ack) begin
                        o_ch_cmd_ack <= owner_oh;
                        timer        <= '0;
                    end
                end
                XFER: begin
                    if (i_wr_finish)
                        o_ch_wr_finish <= owner_oh;
                    else if (tmo_hit)
                        o_timeout <= 1'b1;
                    else
                        timer <= timer + TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Stream path is a pure mux so the DMA sees the owner's beats with no added latency.
    always_comb begin
        o_wr_cmd_req   = (state == REQ);
        o_busy         = (state != IDLE);
        o_dma_wr_valid = 1'b0;
        o_dma_wr_keep  = '0;
        o_dma_wr_data  = '0;
        o_ch_wr_ready  = '0;
        if (state == XFER) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (owner_oh[k]) begin
                    o_dma_wr_valid   = i_ch_wr_valid[k];
                    o_dma_wr_keep    = i_ch_wr_keep[k*KEEP_W +: KEEP_W];
                    o_dma_wr_data    = i_ch_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                    o_ch_wr_ready[k] = i_dma_wr_ready;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_wr_arb.sv
// Bench for tlk2711_wr_arb with four channels and a 16-cycle timeout.
// Expected grants are queued when requests are raised and checked as the DMA command appears.
module tb_tlk2711_wr_arb;

    localparam int NUM_CH  = 4;
    localparam int CMD_W   = 64;
    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int OWNER_W = 2;

    logic                     clk;
    logic                     rst;
    logic                     i_soft_rst;
    logic [NUM_CH-1:0]        i_ch_cmd_req;
    logic [NUM_CH*CMD_W-1:0]  i_ch_cmd_data;
    logic [NUM_CH-1:0]        o_ch_cmd_ack;
    logic [NUM_CH-1:0]        o_ch_wr_finish;
    logic [NUM_CH-1:0]        i_ch_wr_valid;
    logic [NUM_CH*KEEP_W-1:0] i_ch_wr_keep;
    logic [NUM_CH*DATA_W-1:0] i_ch_wr_data;
    logic [NUM_CH-1:0]        o_ch_wr_ready;
    logic                     o_wr_cmd_req;
    logic [CMD_W-1:0]         o_wr_cmd_data;
    logic                     i_wr_cmd_ack;
    logic                     o_dma_wr_valid;
    logic [KEEP_W-1:0]        o_dma_wr_keep;
    logic [DATA_W-1:0]        o_dma_wr_data;
    logic                     i_dma_wr_ready;
    logic                     i_wr_finish;
    logic [OWNER_W-1:0]       o_owner;
    logic                     o_busy;
    logic                     o_timeout;

    typedef struct {
        int          ch;
        logic [63:0] cmd;
    } grant_t;

    grant_t      exp_q[$];
    logic [63:0] cmd_arr  [NUM_CH];
    logic [63:0] data_arr [NUM_CH];
    logic [7:0]  keep_arr [NUM_CH];
    int          checks;
    int          errors;

    tlk2711_wr_arb #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(48), .DLEN_WIDTH(16), .DATA_WIDTH(DATA_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .i_soft_rst(i_soft_rst),
        .i_ch_cmd_req(i_ch_cmd_req), .i_ch_cmd_data(i_ch_cmd_data),
        .o_ch_cmd_ack(o_ch_cmd_ack), .o_ch_wr_finish(o_ch_wr_finish),
        .i_ch_wr_valid(i_ch_wr_valid), .i_ch_wr_keep(i_ch_wr_keep), .i_ch_wr_data(i_ch_wr_data),
        .o_ch_wr_ready(o_ch_wr_ready),
        .o_wr_cmd_req(o_wr_cmd_req), .o_wr_cmd_data(o_wr_cmd_data), .i_wr_cmd_ack(i_wr_cmd_ack),
        .o_dma_wr_valid(o_dma_wr_valid), .o_dma_wr_keep(o_dma_wr_keep), .o_dma_wr_data(o_dma_wr_data),
        .i_dma_wr_ready(i_dma_wr_ready), .i_wr_finish(i_wr_finish),
        .o_owner(o_owner), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            i_ch_cmd_data[k*CMD_W +: CMD_W]   = cmd_arr[k];
            i_ch_wr_data[k*DATA_W +: DATA_W]  = data_arr[k];
            i_ch_wr_keep[k*KEEP_W +: KEEP_W]  = keep_arr[k];
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input int ch);
        grant_t g;
        g.ch  = ch;
        g.cmd = cmd_arr[ch];
        exp_q.push_back(g);
    endtask

    // Waits for the DMA command, checks it against the scoreboard, acks it and checks the ack pulse.
    // Returns one cycle after the ack pulse, i.e. in the second XFER cycle.
    task automatic grant_ack(input int ack_delay, input bit drop_req, output int ch);
        grant_t      g;
        int          n;
        logic [3:0]  exp_ack;
        ch = 0;
        n  = 0;
        while (o_wr_cmd_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (o_wr_cmd_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL grant_wait: o_wr_cmd_req=%b, required 1 within 40 cycles", o_wr_cmd_req);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_grant: owner=%0d, no grant expected", o_owner);
            return;
        end
        g  = exp_q.pop_front();
        ch = g.ch;
        checks++;
        if (o_owner !== OWNER_W'(g.ch)) begin
            errors++;
            $display("[TB] FAIL grant_owner: got %0d, required %0d", o_owner, g.ch);
        end
        checks++;
        if (o_wr_cmd_data !== g.cmd) begin
            errors++;
            $display("[TB] FAIL grant_cmd: got %h, required %h", o_wr_cmd_data, g.cmd);
        end
        for (int i = 1; i < ack_delay; i++) begin
            tick();
            checks++;
            if (o_wr_cmd_req !== 1'b1 || o_wr_cmd_data !== g.cmd) begin
                errors++;
                $display("[TB] FAIL cmd_hold: req=%b data=%h, required req=1 data=%h",
                         o_wr_cmd_req, o_wr_cmd_data, g.cmd);
            end
        end
        i_wr_cmd_ack = 1'b1;
        tick();
        i_wr_cmd_ack = 1'b0;
        exp_ack = 4'b0001 << g.ch;
        checks++;
        if (o_ch_cmd_ack !== exp_ack) begin
            errors++;
            $display("[TB] FAIL cmd_ack: got %b, required %b", o_ch_cmd_ack, exp_ack);
        end
        checks++;
        if (o_wr_cmd_req !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_drop: req=%b busy=%b, required req=0 busy=1", o_wr_cmd_req, o_busy);
        end
        if (drop_req)
            i_ch_cmd_req[g.ch] = 1'b0;
        tick();
        checks++;
        if (o_ch_cmd_ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL ack_pulse: got %b, required 0000", o_ch_cmd_ack);
        end
    endtask

    task automatic finish_xfer(input int ch);
        logic [3:0] exp_fin;
        exp_fin = 4'b0001 << ch;
        i_wr_finish = 1'b1;
        tick();
        i_wr_finish = 1'b0;
        checks++;
        if (o_ch_wr_finish !== exp_fin) begin
            errors++;
            $display("[TB] FAIL wr_finish: got %b, required %b", o_ch_wr_finish, exp_fin);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_finish: busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_owner !== 2'd3) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b owner=%0d, required busy=0 owner=3", o_busy, o_owner);
        end
        checks++;
        if ({o_wr_cmd_req, o_dma_wr_valid, o_timeout, o_ch_cmd_ack, o_ch_wr_finish, o_ch_wr_ready} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: req=%b valid=%b tmo=%b ack=%b fin=%b rdy=%b, required all 0",
                     o_wr_cmd_req, o_dma_wr_valid, o_timeout, o_ch_cmd_ack, o_ch_wr_finish, o_ch_wr_ready);
        end
    endtask

    task automatic test_first_priority();
        int ch;
        i_ch_cmd_req = 4'b0011;
        push_grant(0);
        push_grant(1);
        tick();
        checks++;
        if (o_wr_cmd_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arb_latency: o_wr_cmd_req=%b one cycle after request, required 1", o_wr_cmd_req);
        end
        grant_ack(1, 1'b1, ch);
        tick();
        finish_xfer(ch);
        checks++;
        if (o_wr_cmd_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL regrant_early: o_wr_cmd_req=%b one cycle after finish, required 0", o_wr_cmd_req);
        end
        tick();
        checks++;
        if (o_wr_cmd_req !== 1'b1 || o_owner !== 2'd1) begin
            errors++;
            $display("[TB] FAIL regrant_2cyc: req=%b owner=%0d, required req=1 owner=1", o_wr_cmd_req, o_owner);
        end
        grant_ack(1, 1'b1, ch);
        finish_xfer(ch);
    endtask

    task automatic test_ack_delay();
        int ch;
        cmd_arr[1]   = {16'h0100, 48'h8000_0000};
        i_ch_cmd_req = 4'b0010;
        push_grant(1);
        grant_ack(3, 1'b1, ch);
        finish_xfer(ch);
    endtask

    task automatic test_stream_mux();
        int ch;
        i_ch_wr_valid  = 4'b0011;
        i_dma_wr_ready = 1'b1;
        i_ch_cmd_req   = 4'b0010;
        push_grant(1);
        tick();
        checks++;
        if (o_dma_wr_valid !== 1'b0 || o_ch_wr_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stream_outside_xfer: valid=%b ready=%b, required 0/0000", o_dma_wr_valid, o_ch_wr_ready);
        end
        grant_ack(1, 1'b1, ch);
        for (int i = 0; i < 6; i++) begin
            i_dma_wr_ready   = i[0];
            i_ch_wr_valid[1] = (i != 3);
            data_arr[0]      = {$urandom, $urandom};
            data_arr[1]      = {$urandom, $urandom};
            #1;
            checks++;
            if (o_dma_wr_valid !== (i != 3) || o_dma_wr_data !== data_arr[1] || o_dma_wr_keep !== keep_arr[1]) begin
                errors++;
                $display("[TB] FAIL stream_mux: valid=%b data=%h keep=%h, required %b %h %h",
                         o_dma_wr_valid, o_dma_wr_data, o_dma_wr_keep, (i != 3), data_arr[1], keep_arr[1]);
            end
            checks++;
            if (o_ch_wr_ready !== {2'b00, i[0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL stream_ready: got %b, required %b", o_ch_wr_ready, {2'b00, i[0], 1'b0});
            end
            tick();
        end
        finish_xfer(ch);
        i_ch_wr_valid  = 4'b0000;
        i_dma_wr_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int ch;
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst   = 1'b0;
        i_ch_cmd_req = 4'b1111;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_CH; k++)
                push_grant(k);
        for (int n = 0; n < 8; n++) begin
            grant_ack(1, 1'b0, ch);
            finish_xfer(ch);
        end
        i_ch_cmd_req = 4'b0000;
    endtask

    task automatic test_timeout();
        int ch;
        tick();
        i_ch_cmd_req = 4'b0100;
        push_grant(2);
        grant_ack(1, 1'b1, ch);
        // grant_ack leaves us in XFER cycle 2; walk to cycle 16.
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (o_busy !== 1'b1 || o_timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_early: cycle %0d busy=%b tmo=%b, required 1/0", i + 2, o_busy, o_timeout);
            end
            tick();
        end
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_cycle16: busy=%b, required 1", o_busy);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b1 || o_busy !== 1'b0 || o_ch_wr_finish !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_abort: tmo=%b busy=%b fin=%b, required 1/0/0000",
                     o_timeout, o_busy, o_ch_wr_finish);
        end
        i_wr_finish = 1'b1;
        tick();
        i_wr_finish = 1'b0;
        checks++;
        if (o_timeout !== 1'b0 || o_ch_wr_finish !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_finish: tmo=%b fin=%b busy=%b, required 0/0000/0",
                     o_timeout, o_ch_wr_finish, o_busy);
        end
    endtask

    task automatic test_soft_reset();
        int ch;
        i_ch_cmd_req = 4'b0001;
        push_grant(0);
        grant_ack(1, 1'b1, ch);
        i_ch_wr_valid  = 4'b0001;
        i_dma_wr_ready = 1'b1;
        #1;
        checks++;
        if (o_dma_wr_valid !== 1'b1 || o_ch_wr_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL pre_soft_rst: valid=%b ready=%b, required 1/0001", o_dma_wr_valid, o_ch_wr_ready);
        end
        i_soft_rst = 1'b1;
        tick();
        i_soft_rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_dma_wr_valid !== 1'b0 || o_owner !== 2'd3 || o_ch_wr_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL soft_rst: busy=%b valid=%b owner=%0d ready=%b, required 0/0/3/0000",
                     o_busy, o_dma_wr_valid, o_owner, o_ch_wr_ready);
        end
        i_ch_wr_valid  = 4'b0000;
        i_dma_wr_ready = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        i_soft_rst     = 1'b0;
        i_ch_cmd_req   = '0;
        i_ch_wr_valid  = '0;
        i_wr_cmd_ack   = 1'b0;
        i_dma_wr_ready = 1'b0;
        i_wr_finish    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cmd_arr[k]  = {16'(k + 1) << 4, 48'h0000_1000_0000 + 48'(k) * 48'h1_0000};
            data_arr[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
            keep_arr[k] = 8'hFF >> k;
        end

        test_reset();
        test_first_priority();
        test_ack_delay();
        test_stream_mux();
        test_fairness();
        test_timeout();
        test_soft_reset();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
